uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (ports clk, resetn).
REQ-002 Parameter CLKS_PER_BIT SHALL default to 218 (10 MHz clk, 21.8 us bit period); legal range is 16..4095.
REQ-003 Parameter FIFO_DEPTH SHALL default to 4 and be a power of two in 2..16.
REQ-004 Port clk SHALL be an input, width 1: system clock, rising-edge active.
REQ-005 Port resetn SHALL be an input, width 1: asynchronous active-low reset.
REQ-006 Port rxd SHALL be an input, width 1: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port rd_data SHALL be an output, width 8: FIFO head byte (show-ahead).
REQ-008 Port rd_valid SHALL be an output, width 1: FIFO not empty.
REQ-009 Port rd_ready SHALL be an input, width 1: consumer pops the head when rd_valid=1.
REQ-010 Port busy SHALL be an output, width 1: receiver FSM is not IDLE.
REQ-011 Port frame_err SHALL be an output, width 1: sticky flag, set when a stop bit samples 0.
REQ-012 Port overrun SHALL be an output, width 1: sticky flag, set when a byte is dropped because the FIFO is full.
REQ-013 Port err_clr SHALL be an input, width 1: clears frame_err and overrun.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use the synchronized value rxs.
REQ-015 The FSM SHALL have the states IDLE, START, DATA and STOP, plus a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-016 IDLE: a falling edge of rxs (previous 1, current 0) SHALL move to START with the counter cleared; a line held low SHALL NOT retrigger.
REQ-017 START: when the counter reaches CLKS_PER_BIT/2-1 (integer division), if rxs=0 the FSM SHALL move to DATA with the counter cleared; otherwise it SHALL return to IDLE as a glitch, with no flag and no byte.
REQ-018 DATA: every CLKS_PER_BIT clocks, rxs SHALL be shifted into bit[index], LSB first; after index 7 the FSM SHALL move to STOP.
REQ-019 STOP: after CLKS_PER_BIT clocks rxs SHALL be sampled once, and the FSM SHALL return to IDLE on the next cycle.
REQ-020 If the stop bit is 1 and the FIFO is not full, the byte SHALL be pushed; rd_valid SHALL go high on the cycle after the stop sample.
REQ-021 If the stop bit is 1 and the FIFO is full with no pop in the same cycle, the byte SHALL be dropped, overrun SHALL be set, and the FIFO SHALL be unchanged.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full (no overrun) or empty-after-pop; the occupancy is then unchanged.
REQ-023 If the stop bit is 0, the byte SHALL be discarded and frame_err SHALL be set.
REQ-024 The FIFO SHALL use read and write pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-025 A pop SHALL occur only when rd_valid and rd_ready are both 1; rd_ready while empty SHALL be ignored.
REQ-026 rd_data SHALL always reflect the head entry combinationally from the registered pointer; its value when empty is don't-care.
REQ-027 err_clr SHALL clear both flags on the next edge; if a set and err_clr coincide, the set SHALL win.
REQ-028 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-029 resetn=0 SHALL immediately force: FSM to IDLE, counters 0, synchronizer flops 1, FIFO pointers 0, rd_valid 0, busy 0, frame_err 0, overrun 0, rd_data 0x00.
REQ-030 A reset asserted mid-byte SHALL discard the partial byte; the first falling edge after reset release SHALL start a fresh frame.

Verification
REQ-031 Send 0x35 at 218 clk/bit with rd_ready=1 -> rd_valid pulses for exactly 1 cycle with rd_data=0x35; no flags set.
REQ-032 With rd_ready=0, send 0x35, 0x37, 0x38, 0x0D, then 0x31 -> overrun=1 after the 5th stop sample; pops then return 0x35, 0x37, 0x38, 0x0D, and the FIFO is then empty.
REQ-033 Drive rxd low for 50 clocks, then high -> busy goes 1 then 0, no byte is pushed, and no flag is set.
REQ-034 Send 0x41 with the stop bit driven 0 -> frame_err=1 and rd_valid stays 0; pulse err_clr -> frame_err=0.
REQ-035 Pulse resetn low during bit 3 of 0x41, then send 0x33 -> only 0x33 is received, and all outputs matched reset values during reset.
REQ-036 With the FIFO full, assert rd_ready on the same cycle as the stop sample of 0x0D -> no overrun, occupancy stays 4, and 0x0D is last in order.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Purpose : 8N1 UART receiver feeding a small show-ahead byte FIFO, with sticky framing/overrun flags.
// Latency : a byte is visible on rd_valid/rd_data the cycle after its stop bit is sampled.
// Backpressure: rd_ready pops the head; a byte that arrives with the FIFO full (and no pop that cycle) is dropped and flagged.
//
// Ports:
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   rxd       raw serial line (idle high, 8N1, LSB first), synchronized internally
//   rd_data   FIFO head byte, 0x00 while empty
//   rd_valid  FIFO not empty
//   rd_ready  consumer accepts the head when rd_valid is high
//   busy      receiver is inside a frame (not IDLE)
//   frame_err sticky: a stop bit sampled low
//   overrun   sticky: a good byte was dropped because the FIFO was full
//   err_clr   clears both sticky flags (a coincident set wins)

// Purpose : generic show-ahead FIFO, extra-MSB pointers for full/empty.
// Latency : a push is visible at the head the cycle after it is written.
// Backpressure: push_rdy drops when full unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push_fire;
  logic             pop_fire;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indexes with differing wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_vld   = !empty;
  assign pop_fire  = pop_vld && pop_rdy;
  // A pop in the same cycle frees the slot the push lands in, so a full
  // FIFO still accepts a push when it is being read.
  assign push_rdy  = !full || pop_fire;
  assign push_fire = push_vld && push_rdy;

  // When full, the write slot and the head slot coincide; the head is read
  // combinationally before the edge, so overwriting it on a pop is safe.
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// Purpose : UART 8N1 receiver with a byte FIFO and sticky error flags.
// Latency : stop-bit sample to rd_valid is one cycle; rxd to internal use is two cycles (synchronizer).
// Backpressure: FIFO full with no pop drops the incoming byte and sets overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 218,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Last count of a full bit period, and of the half period that moves the
  // sampling point from the start edge to mid-bit.
  localparam logic [11:0] CNT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta;
  logic        rxs;
  logic        rxs_d;
  logic        rx_fall;

  logic [1:0]  state;
  logic [11:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_dat;

  logic        stop_smp;
  logic        byte_vld;
  logic        byte_rdy;
  logic        frame_bad;
  logic        overrun_set;

  // Two-flop synchronizer plus one history flop for edge detection. All
  // flops reset to the idle level so reset release never looks like a start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // Only a true 1->0 transition starts a frame; a line parked low after a
  // frame error cannot retrigger.
  assign rx_fall = rxs_d && !rxs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_dat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (rx_fall) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state   <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            bit_cnt <= bit_cnt + 12'd1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt            <= '0;
            shift_dat[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 12'd1;
          end
        end
        ST_STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 12'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // The stop bit is sampled exactly once, on the last count of STOP; the
  // push (or the error) is committed on that same edge.
  assign stop_smp    = (state == ST_STOP) && (bit_cnt == CNT_LAST);
  assign byte_vld    = stop_smp && rxs;
  assign frame_bad   = stop_smp && !rxs;
  assign overrun_set = byte_vld && !byte_rdy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_vld (byte_vld),
    .push_rdy (byte_rdy),
    .push_dat (shift_dat),
    .pop_vld  (rd_valid),
    .pop_rdy  (rd_ready),
    .pop_dat  (rd_data)
  );

  // Sticky flags: a set in the same cycle as err_clr takes priority so no
  // event is ever lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_bad) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
